// File: rtl/add_tc_stage.sv
// Issue/capture stage around an external 32-bit adder: registers operand pairs onto the
// adder, captures the mode-corrected 33-bit sum with an overflow flag into a 2-entry FIFO.
module add_tc_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_tc,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [32:0] add_sum,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [32:0] out_sum,
  output logic        out_ovf,
  output logic [15:0] ovf_cnt
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [31:0] a_q, b_q;
  logic        tc_q, s1v_q;
  logic [32:0] sum_mem_q [2];
  logic        ovf_mem_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] ovf_cnt_q, ovf_cnt_d;
  logic [1:0]  occ;
  logic        pop, accept;
  logic [32:0] cap_sum;
  logic        cap_ovf;
  logic        a_sign, b_sign;

  assign a_sign    = a_q[31];
  assign b_sign    = b_q[31];
  assign occ       = cnt_q + {1'b0, s1v_q};
  assign out_valid = (cnt_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign in_ready  = (occ < 2'd2) | pop;
  assign accept    = in_valid & in_ready;

  // In signed mode the true 33-bit sign is the carry-out corrected by the operand signs.
  always_comb begin
    cap_sum = add_sum;
    cap_ovf = add_sum[32];
    if (tc_q) begin
      cap_sum[32] = a_sign ^ b_sign ^ add_sum[32];
      cap_ovf     = (a_sign == b_sign) & (add_sum[31] != a_sign);
    end
  end

  always_comb begin
    cnt_d     = cnt_q + {1'b0, s1v_q} - {1'b0, pop};
    ovf_cnt_d = ovf_cnt_q;
    if (s1v_q && cap_ovf) ovf_cnt_d = sat_inc16(ovf_cnt_q);
  end

  // Stage s1: issue register and FIFO control
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      tc_q      <= 1'b0;
      s1v_q     <= 1'b0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
      ovf_cnt_q <= 16'd0;
    end else begin
      if (accept) begin
        a_q  <= in_a;
        b_q  <= in_b;
        tc_q <= in_tc;
      end
      s1v_q     <= accept;
      if (s1v_q) wr_ptr_q <= ~wr_ptr_q;
      if (pop)   rd_ptr_q <= ~rd_ptr_q;
      cnt_q     <= cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  // Stage s2: result capture into FIFO storage
  always_ff @(posedge clk) begin
    if (s1v_q) begin
      sum_mem_q[wr_ptr_q] <= cap_sum;
      ovf_mem_q[wr_ptr_q] <= cap_ovf;
    end
  end

  assign add_a   = a_q;
  assign add_b   = b_q;
  assign out_sum = sum_mem_q[rd_ptr_q];
  assign out_ovf = ovf_mem_q[rd_ptr_q];
  assign ovf_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_add_tc_stage.sv
// Bench for add_tc_stage: arithmetic reference model with a result queue, directed
// corner cases, backpressure, full-rate streaming, reset flush and random traffic.
module tb_add_tc_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_tc, out_valid, out_ready, out_ovf;
  logic [31:0] in_a, in_b, add_a, add_b;
  logic [32:0] add_sum, out_sum;
  logic [15:0] ovf_cnt;

  always #5 clk = ~clk;

  // Behavioural combinational adder feeding the stage
  assign add_sum = {1'b0, add_a} + {1'b0, add_b};

  add_tc_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tc(in_tc), .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .ovf_cnt(ovf_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, sum[32:0]} from true integer arithmetic
  localparam longint MAXU = 64'h0000_0000_FFFF_FFFF;
  localparam longint MAXS = 64'h0000_0000_7FFF_FFFF;
  localparam longint MINS = -64'sh0000_0000_8000_0000;

  function automatic logic [33:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic tc);
    longint s;
    logic   o;
    if (tc) begin
      s = longint'($signed(a)) + longint'($signed(b));
      o = (s > MAXS) || (s < MINS);
    end else begin
      s = longint'(a) + longint'(b);
      o = (s > MAXU);
    end
    return {o, s[32:0]};
  endfunction

  logic [33:0] q_res[$];
  logic        pend_v;
  logic [33:0] pend_r;
  logic [31:0] last_a, last_b;
  int          m_cnt;
  int          cyc_n = 0;
  logic [32:0] got_q[$];
  int          got_t[$];

  task automatic model_clear();
    q_res.delete();
    pend_v = 1'b0;
    pend_r = '0;
    last_a = '0;
    last_b = '0;
    m_cnt  = 0;
  endtask

  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] b,
                     input logic tc, input logic ordy, input logic rstn, output logic acc);
    logic exp_ov, exp_ir, pop;
    in_valid = v; in_a = a; in_b = b; in_tc = tc; out_ready = ordy; rst_n = rstn;
    @(negedge clk);
    exp_ov = (q_res.size() != 0);
    exp_ir = ((q_res.size() + int'(pend_v)) < 2) || (exp_ov && ordy);
    chk("in_ready", in_ready, exp_ir);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      chk("out_sum", out_sum, q_res[0][32:0]);
      chk("out_ovf", out_ovf, q_res[0][33]);
    end
    chk("ovf_cnt", ovf_cnt, m_cnt);
    chk("add_a", add_a, last_a);
    chk("add_b", add_b, last_b);
    acc = rstn && v && exp_ir;
    pop = rstn && exp_ov && ordy;
    if (rstn && out_valid && ordy) begin
      got_q.push_back(out_sum);
      got_t.push_back(cyc_n);
    end
    @(posedge clk);
    cyc_n++;
    if (!rstn) begin
      model_clear();
    end else begin
      if (pop) void'(q_res.pop_front());
      if (pend_v) begin
        q_res.push_back(pend_r);
        if (pend_r[33] && m_cnt < 65535) m_cnt++;
      end
      pend_v = acc;
      if (acc) begin
        pend_r = ref_res(a, b, tc);
        last_a = a;
        last_b = b;
      end
    end
    #1;
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic tc, input logic [32:0] es, input logic eo);
    logic acc;
    cyc(1'b1, a, b, tc, 1'b0, 1'b1, acc);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_sum"}, out_sum, es);
    chk({tag, "_ovf"}, out_ovf, eo);
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   idx;
    logic [31:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b1; in_a = '0; in_b = '0; in_tc = 1'b0; out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_ovf_cnt", ovf_cnt, 16'd0);

    // Directed corner cases
    directed("ucarry", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000, 1'b1);
    chk("ucarry_cnt", ovf_cnt, 16'd1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, acc);
    directed("sovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 33'h0_8000_0000, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, acc);
    directed("sneg", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFE, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, acc);
    directed("uneg", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33'h1_FFFF_FFFE, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, acc);
    chk("dir_cnt", ovf_cnt, 16'd3);

    // Backpressure: out_ready low, in_valid held
    got_q.delete(); got_t.delete();
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, idx + 1, idx + 1, 1'b0, 1'b0, 1'b1, acc);
      if (acc) idx++;
    end
    chk("bp_accepted", idx, 2);
    chk("bp_in_ready", in_ready, 1'b0);
    for (int i = 0; i < 20 && (idx < 4 || q_res.size() != 0 || pend_v); i++) begin
      cyc(idx < 4, idx + 1, idx + 1, 1'b0, 1'b1, 1'b1, acc);
      if (acc) idx++;
    end
    chk("bp_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      chk("bp_order", got_q[i], 2 * (i + 1));

    // Full-rate streaming
    got_q.delete(); got_t.delete();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b1, acc);
      chk("stream_acc", acc, 1'b1);
    end
    for (int i = 0; i < 5 && (q_res.size() != 0 || pend_v); i++)
      cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, acc);
    chk("stream_count", got_q.size(), 8);
    for (int i = 1; i < got_t.size(); i++)
      chk("stream_back2back", got_t[i], got_t[0] + i);

    // Reset with results pending
    cyc(1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, acc);
    cyc(1'b1, 32'h5, 32'h6, 1'b0, 1'b0, 1'b1, acc);
    cyc(1'b1, 32'h7, 32'h8, 1'b1, 1'b0, 1'b0, acc);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_ovf_cnt", ovf_cnt, 16'd0);
    chk("flush_add_a", add_a, 32'd0);
    got_q.delete(); got_t.delete();
    for (int i = 0; i < 3; i++)
      cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, acc);
    chk("flush_no_stale", got_q.size(), 0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      ra = pick_op();
      rb = pick_op();
      cyc(1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) != 0), acc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
